mult_arbiter: RTL and testbench

//  Shares one shift-add multiplier (start/ready/product interface) among NUM_REQ requesters.

---
 rtl/mult_arb_pkg.sv | 23 ++
 rtl/mult_arbiter_rr_pick.sv | 32 +++
 rtl/mult_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mult_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and constants for the multiplier arbiter.
//   arb_state_t      - arbiter FSM state encoding
//   DEFAULT_*        - default parameter values for mult_arbiter
//   rr_next()        - round-robin pointer advance with wrap
package mult_arb_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 4;
  localparam int unsigned DEFAULT_NUM_REQ = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Index following idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_valid  in   NUM_REQ  request vector
//   i_ptr    in   IDX_W    highest-priority index for this pick
//   o_idx    out  IDX_W    first valid index at or after i_ptr (wrapping)
//   o_any    out  1        at least one request is valid
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_cand;

  // Scan from the pointer outward; the first hit wins.
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_valid[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one start/ready multiplier among NUM_REQ requesters.
// Round-robin grant, operand capture, single job in flight, tagged response.
//
// Ports:
//   clk_in, rst_in         clock, asynchronous active-low reset
//   req_valid/x/y          per-requester request and packed operands
//   req_ready              one-hot accept pulse
//   rsp_valid/id/product   one-cycle result pulse, id and held product
//   rsp_err                watchdog abort flag (valid with rsp_valid)
//   m_start/m_x/m_y        multiplier start pulse and operands
//   m_product/m_ready      multiplier result and done level
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to enable the WAIT-state
// watchdog (TIMEOUT cycles); otherwise rsp_err is tied low.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter  int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter  int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [IDX_W-1:0]         rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     rsp_err,
  output logic                     m_start,
  output logic [WIDTH-1:0]         m_x,
  output logic [WIDTH-1:0]         m_y,
  input  logic [2*WIDTH-1:0]       m_product,
  input  logic                     m_ready
);

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_id;
  logic [IDX_W-1:0]   r_rsp_id;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_product;
  logic               r_m_ready_q;

  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any;
  logic [WIDTH-1:0]   w_sel_x;
  logic [WIDTH-1:0]   w_sel_y;
  logic               w_accept;
  logic               w_edge;
  logic               w_done;
  logic               w_timeout;
  logic               w_expire;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  assign w_sel_x = req_x[32'(w_grant_idx) * WIDTH +: WIDTH];
  assign w_sel_y = req_y[32'(w_grant_idx) * WIDTH +: WIDTH];

  // Only a fresh rising edge counts as completion; a ready level left high
  // by the previous job must not finish the current one.
  assign w_edge = m_ready & ~r_m_ready_q;

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    m_start      = 1'b0;
    rsp_valid    = 1'b0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready[w_grant_idx] = 1'b1;
          w_accept               = 1'b1;
          w_state_next           = ISSUE;
        end
      end
      ISSUE: begin
        m_start      = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        // Completion wins if it lands on the same cycle as the watchdog.
        if (w_edge) begin
          w_done       = 1'b1;
          w_state_next = RESP;
        end else if (w_expire) begin
          w_timeout    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_rsp_id    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_product   <= '0;
      r_m_ready_q <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_m_ready_q <= m_ready;
      if (w_accept) begin
        r_ptr <= IDX_W'(rr_next(32'(w_grant_idx), NUM_REQ));
        r_id  <= w_grant_idx;
        r_x   <= w_sel_x;
        r_y   <= w_sel_y;
      end
      if (w_done) begin
        r_product <= m_product;
        r_rsp_id  <= r_id;
      end else if (w_timeout) begin
        r_product <= '0;
        r_rsp_id  <= r_id;
      end
    end
  end

  assign m_x         = r_x;
  assign m_y         = r_y;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_product;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err;

  // Counter restarts on every ISSUE so each job gets the full budget.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == ISSUE) begin
        r_wait_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_done) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_expire = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign rsp_err  = rsp_valid & r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_expire         = 1'b0;
  assign rsp_err          = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: randomized self-checking bench for mult_arbiter with a
// behavioural shift-add multiplier and a queue-based round-robin model.
// Define MULT_ARB_TIMEOUT_EN (for both bench and RTL) to add the watchdog test.
`timescale 1ns/1ps
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 8;
  // Accept, ISSUE, four busy cycles plus one to raise ready, edge seen, RESP.
  localparam int ACC_TO_RSP = 8;
  // Accept, ISSUE, then TO cycles in WAIT before RESP.
  localparam int ACC_TO_TMO = 2 + TO;

  typedef struct {
    int       id;
    logic [3:0] x;
    logic [3:0] y;
  } op_t;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N*W-1:0] req_y = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_product;
  logic           rsp_err;
  logic           m_start;
  logic [W-1:0]   m_x;
  logic [W-1:0]   m_y;
  logic           mul_ready;
  logic [2*W-1:0] mul_acc;

  mult_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .m_start     (m_start),
    .m_x         (m_x),
    .m_y         (m_y),
    .m_product   (mul_acc),
    .m_ready     (mul_ready)
  );

  always #5 clk = ~clk;

  // Shift-add multiplier. stale_mode keeps the old ready level for two cycles
  // after start; stuck_mode never raises ready.
  logic [2*W-1:0] mul_addend;
  logic [W-1:0]   mul_b;
  int             mul_busy, mul_hold;
  bit             mul_job, stale_mode = 0, stuck_mode = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_ready <= 1'b0; mul_acc <= '0; mul_addend <= '0; mul_b <= '0;
      mul_busy <= 0; mul_hold <= 0; mul_job <= 1'b0;
    end else if (m_start) begin
      mul_acc <= '0; mul_addend <= {4'b0, m_x}; mul_b <= m_y; mul_busy <= W; mul_job <= 1'b1;
      if (stale_mode) mul_hold <= 2;
      else begin mul_hold <= 0; mul_ready <= 1'b0; end
    end else begin
      if (mul_busy > 0) begin
        if (mul_b[0]) mul_acc <= mul_acc + mul_addend;
        mul_addend <= mul_addend << 1;
        mul_b      <= mul_b >> 1;
        mul_busy   <= mul_busy - 1;
      end
      if (mul_hold > 0) begin
        mul_hold <= mul_hold - 1;
        if (mul_hold == 1) mul_ready <= 1'b0;
      end else if (mul_busy == 0 && mul_job && !stuck_mode) begin
        mul_ready <= 1'b1;
        mul_job   <= 1'b0;
      end
    end
  end

  // Clients: each requester presents its oldest pending op until accepted.
  op_t          ops[$];
  logic [N-1:0] seen_ready = '0;

  always @(negedge clk) seen_ready = rst_n ? req_ready : '0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (seen_ready[i]) begin
        for (int k = 0; k < ops.size(); k++) begin
          if (ops[k].id == i) begin ops.delete(k); break; end
        end
      end
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < ops.size(); k++) begin
        if (ops[k].id == i) begin
          req_valid[i] = 1'b1;
          req_x[i*W +: W] = ops[k].x;
          req_y[i*W +: W] = ops[k].y;
          break;
        end
      end
    end
  end

  // Monitor: log grants and responses with their cycle numbers.
  int             cyc = 0;
  logic [N-1:0]   g_vec[$];
  int             g_cyc[$];
  int             r_id[$];
  logic [2*W-1:0] r_prod[$];
  logic           r_err[$];
  int             r_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin g_vec.push_back(req_ready); g_cyc.push_back(cyc); end
      if (rsp_valid) begin
        r_id.push_back(int'(rsp_id)); r_prod.push_back(rsp_product);
        r_err.push_back(rsp_err); r_cyc.push_back(cyc);
      end
    end
  end

  // Reference model: pending ops are served one at a time; each grant goes to
  // the first requester with work at or after the pointer, then the pointer
  // moves just past it.
  int mptr = 0;
  int exp_id[$];
  int exp_prod[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic plan();
    op_t pend[$];
    pend = ops;
    exp_id.delete(); exp_prod.delete();
    while (pend.size() > 0) begin
      for (int k = 0; k < N; k++) begin
        int i = (mptr + k) % N;
        int pos = -1;
        for (int j = 0; j < pend.size(); j++) if (pend[j].id == i) begin pos = j; break; end
        if (pos >= 0) begin
          exp_id.push_back(i);
          exp_prod.push_back(int'(pend[pos].x) * int'(pend[pos].y));
          pend.delete(pos);
          mptr = (i + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic clear_logs();
    g_vec.delete(); g_cyc.delete(); r_id.delete(); r_prod.delete(); r_err.delete(); r_cyc.delete();
  endtask

  task automatic add_op(input int id, input logic [3:0] x, input logic [3:0] y);
    op_t o;
    o.id = id; o.x = x; o.y = y;
    ops.push_back(o);
  endtask

  task automatic wait_rsp(input int n);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      if (r_id.size() >= n) break;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; ops.delete(); mptr = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_err, m_start} !== 3'b0 || rsp_id !== 2'd0 || rsp_product !== 8'd0 ||
        m_x !== 4'd0 || m_y !== 4'd0 || req_ready !== 4'd0) begin
      n_err++;
      $display("FAIL reset outputs: got v=%b e=%b s=%b id=%0d p=%0d mx=%0d my=%0d rdy=%b, want all 0",
               rsp_valid, rsp_err, m_start, rsp_id, rsp_product, m_x, m_y, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic test_single();
    clear_logs(); add_op(2, 4'd3, 4'd5); plan();
    wait_rsp(exp_id.size());
    n_vec++;
    if (r_id.size() != exp_id.size()) begin
      n_err++; $display("FAIL single count: got %0d, want %0d", r_id.size(), exp_id.size());
    end
    for (int k = 0; k < exp_id.size() && k < r_id.size(); k++) begin
      n_vec++;
      if (r_id[k] !== exp_id[k] || r_prod[k] !== 8'(exp_prod[k]) || r_err[k] !== 1'b0 ||
          g_vec[k] !== N'(1 << exp_id[k]) || r_cyc[k] - g_cyc[k] != ACC_TO_RSP) begin
        n_err++;
        $display("FAIL single job%0d: got id=%0d p=%0d e=%b g=%b lat=%0d, want id=%0d p=%0d e=0 g=%b lat=%0d",
                 k, r_id[k], r_prod[k], r_err[k], g_vec[k], r_cyc[k] - g_cyc[k], exp_id[k],
                 exp_prod[k], N'(1 << exp_id[k]), ACC_TO_RSP);
      end
    end
    n_vec++;
    if (rsp_product !== 8'd15) begin
      n_err++; $display("FAIL single hold: got product %0d after pulse, want 15", rsp_product);
    end
  endtask

  task automatic test_all_at_once();
    test_reset();
    for (int i = N - 1; i >= 0; i--) add_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    plan();
    wait_rsp(exp_id.size());
    n_vec++;
    if (r_id.size() != exp_id.size()) begin
      n_err++; $display("FAIL all4 count: got %0d, want %0d", r_id.size(), exp_id.size());
    end
    for (int k = 0; k < exp_id.size() && k < r_id.size(); k++) begin
      n_vec++;
      if (r_id[k] !== exp_id[k] || r_prod[k] !== 8'(exp_prod[k]) || r_err[k] !== 1'b0 ||
          g_vec[k] !== N'(1 << exp_id[k]) || r_cyc[k] - g_cyc[k] != ACC_TO_RSP) begin
        n_err++;
        $display("FAIL all4 job%0d: got id=%0d p=%0d e=%b g=%b lat=%0d, want id=%0d p=%0d e=0 g=%b lat=%0d",
                 k, r_id[k], r_prod[k], r_err[k], g_vec[k], r_cyc[k] - g_cyc[k], exp_id[k],
                 exp_prod[k], N'(1 << exp_id[k]), ACC_TO_RSP);
      end
    end
  endtask

  task automatic test_back_to_back();
    stale_mode = 1;
    clear_logs(); add_op(0, 4'd15, 4'd15); add_op(0, 4'd0, 4'd9); plan();
    wait_rsp(exp_id.size());
    n_vec++;
    if (r_id.size() != exp_id.size()) begin
      n_err++; $display("FAIL b2b count: got %0d, want %0d", r_id.size(), exp_id.size());
    end
    for (int k = 0; k < exp_id.size() && k < r_id.size(); k++) begin
      n_vec++;
      if (r_id[k] !== exp_id[k] || r_prod[k] !== 8'(exp_prod[k]) || r_err[k] !== 1'b0 ||
          g_vec[k] !== N'(1 << exp_id[k]) || r_cyc[k] - g_cyc[k] != ACC_TO_RSP) begin
        n_err++;
        $display("FAIL b2b job%0d: got id=%0d p=%0d e=%b g=%b lat=%0d, want id=%0d p=%0d e=0 g=%b lat=%0d",
                 k, r_id[k], r_prod[k], r_err[k], g_vec[k], r_cyc[k] - g_cyc[k], exp_id[k],
                 exp_prod[k], N'(1 << exp_id[k]), ACC_TO_RSP);
      end
    end
    stale_mode = 0;
  endtask

  task automatic test_fairness();
    clear_logs();
    for (int r = 0; r < 2; r++) begin
      add_op(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      add_op(3, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    plan();
    wait_rsp(exp_id.size());
    n_vec++;
    if (r_id.size() != exp_id.size()) begin
      n_err++; $display("FAIL fair count: got %0d, want %0d", r_id.size(), exp_id.size());
    end
    for (int k = 0; k < exp_id.size() && k < r_id.size(); k++) begin
      n_vec++;
      if (r_id[k] !== exp_id[k] || r_prod[k] !== 8'(exp_prod[k]) || r_err[k] !== 1'b0 ||
          g_vec[k] !== N'(1 << exp_id[k]) || r_cyc[k] - g_cyc[k] != ACC_TO_RSP) begin
        n_err++;
        $display("FAIL fair job%0d: got id=%0d p=%0d e=%b g=%b lat=%0d, want id=%0d p=%0d e=0 g=%b lat=%0d",
                 k, r_id[k], r_prod[k], r_err[k], g_vec[k], r_cyc[k] - g_cyc[k], exp_id[k],
                 exp_prod[k], N'(1 << exp_id[k]), ACC_TO_RSP);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    clear_logs(); add_op(1, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
    for (int c = 0; c < 50 && g_vec.size() == 0; c++) @(posedge clk);
    repeat (4) @(negedge clk);
    rst_n = 1'b0; ops.delete();
    repeat (2) @(negedge clk);
    n_vec++;
    if (g_vec.size() != 1 || r_id.size() != 0 || rsp_valid !== 1'b0 || m_start !== 1'b0) begin
      n_err++;
      $display("FAIL midreset abort: got grants=%0d rsps=%0d v=%b s=%b, want grants=1 rsps=0 v=0 s=0",
               g_vec.size(), r_id.size(), rsp_valid, m_start);
    end
    rst_n = 1'b1; mptr = 0;
    @(negedge clk);
    clear_logs();
    add_op(3, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    add_op(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    plan();
    wait_rsp(exp_id.size());
    n_vec++;
    if (r_id.size() != exp_id.size()) begin
      n_err++; $display("FAIL midreset count: got %0d, want %0d", r_id.size(), exp_id.size());
    end
    for (int k = 0; k < exp_id.size() && k < r_id.size(); k++) begin
      n_vec++;
      if (r_id[k] !== exp_id[k] || r_prod[k] !== 8'(exp_prod[k]) || r_err[k] !== 1'b0 ||
          g_vec[k] !== N'(1 << exp_id[k]) || r_cyc[k] - g_cyc[k] != ACC_TO_RSP) begin
        n_err++;
        $display("FAIL midreset job%0d: got id=%0d p=%0d e=%b g=%b lat=%0d, want id=%0d p=%0d e=0 g=%b lat=%0d",
                 k, r_id[k], r_prod[k], r_err[k], g_vec[k], r_cyc[k] - g_cyc[k], exp_id[k],
                 exp_prod[k], N'(1 << exp_id[k]), ACC_TO_RSP);
      end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      int mask = $urandom_range(1, 15);
      clear_logs();
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          int cnt = $urandom_range(1, 2);
          for (int j = 0; j < cnt; j++) add_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
      end
      plan();
      wait_rsp(exp_id.size());
      n_vec++;
      if (r_id.size() != exp_id.size()) begin
        n_err++; $display("FAIL random%0d count: got %0d, want %0d", round, r_id.size(), exp_id.size());
      end
      for (int k = 0; k < exp_id.size() && k < r_id.size(); k++) begin
        n_vec++;
        if (r_id[k] !== exp_id[k] || r_prod[k] !== 8'(exp_prod[k]) || r_err[k] !== 1'b0 ||
            g_vec[k] !== N'(1 << exp_id[k]) || r_cyc[k] - g_cyc[k] != ACC_TO_RSP) begin
          n_err++;
          $display("FAIL random%0d job%0d: got id=%0d p=%0d e=%b g=%b lat=%0d, want id=%0d p=%0d g=%b lat=%0d",
                   round, k, r_id[k], r_prod[k], r_err[k], g_vec[k], r_cyc[k] - g_cyc[k],
                   exp_id[k], exp_prod[k], N'(1 << exp_id[k]), ACC_TO_RSP);
        end
      end
    end
  endtask

`ifdef MULT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    stuck_mode = 1;
    clear_logs(); add_op(2, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))); plan();
    wait_rsp(exp_id.size());
    n_vec++;
    if (r_id.size() != 1) begin
      n_err++; $display("FAIL timeout count: got %0d, want 1", r_id.size());
    end else if (r_id[0] !== 2 || r_prod[0] !== 8'd0 || r_err[0] !== 1'b1 ||
                 r_cyc[0] - g_cyc[0] != ACC_TO_TMO) begin
      n_err++;
      $display("FAIL timeout rsp: got id=%0d p=%0d e=%b lat=%0d, want id=2 p=0 e=1 lat=%0d",
               r_id[0], r_prod[0], r_err[0], r_cyc[0] - g_cyc[0], ACC_TO_TMO);
    end
    n_vec++;
    if (rsp_err !== 1'b0) begin
      n_err++; $display("FAIL timeout errlevel: got rsp_err=%b outside pulse, want 0", rsp_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_at_once();
    test_back_to_back();
    test_fairness();
    test_reset_mid_job();
    test_random();
`ifdef MULT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
